// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle main control FSM and the downstream ALU control decoder.
// Holds opcodes, alu_op codes, mux-select encodings, the state enumeration and the control bundle.
package multicycle_control_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_NORI  = 4'b0100;
    localparam logic [3:0] OP_SLTI  = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_J     = 4'b1010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_NOR   = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic state_e decode_next(input logic [3:0] op);
        case (op)
            OP_RTYPE:                                  return S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_SLTI: return S_EXEC_I;
            OP_LW, OP_SW:                              return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                            return S_BRANCH;
            OP_J:                                      return S_JUMP;
            default:                                   return S_ILLEGAL;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_NORI: return ALU_NOR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/handshake bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       alu_op;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_count;
    logic [3:0]       state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
               instr_done, illegal_op, retired_count, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
               instr_done, illegal_op, retired_count, state
    );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: Moore control outputs per state, memory stalls on mem_ready,
// opcode captured in DECODE, and a wrapping retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= OP_RTYPE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        ctrl     = '0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = bus.mem_ready;
                ctrl.ir_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d       = bus.opcode;
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALU_ADD;
                state_d        = decode_next(bus.opcode);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_RTYPE;
                state_d        = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_alu_op(opcode_q);
                state_d        = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (opcode_q == OP_RTYPE);
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_RT;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_write   = bus.zero ^ (opcode_q == OP_BNE);
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
                state_d         = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ctrl.instr_done};
    end

    // Outputs are held at zero for as long as reset is high, even before the first edge.
    always_comb begin
        ctrl_out = reset ? '0 : ctrl;
    end

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.instr_done    = ctrl_out.instr_done;
    assign bus.illegal_op    = ctrl_out.illegal_op;
    assign bus.retired_count = reset ? '0 : cnt_q;
    assign bus.state         = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    localparam int TB_CNT_W = 8;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_ALU_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_MEM_WB   = 4'd7;
    localparam logic [3:0] ST_MEM_WR   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_ILLEGAL  = 4'd11;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        string               name;
        logic [3:0]          st;
        ctl_t                ctl;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;
    exp_t exp_q[$];

    multicycle_control_if #(.CNT_W(TB_CNT_W)) bus ();

    multicycle_control #(.CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: the DUT presents a full control word every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            ctl_t got;
            e = exp_q.pop_front();
            got = '{bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                    bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                    bus.alu_op, bus.instr_done, bus.illegal_op};
            check({e.name, ".state"}, 32'(bus.state), 32'(e.st));
            check({e.name, ".ctl"}, 32'(got), 32'(e.ctl));
            check({e.name, ".count"}, 32'(bus.retired_count), 32'(e.cnt));
        end
    end

    // Hand-written expected control words, one per state of the operation table.
    function automatic ctl_t c_fetch(input logic mr);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.pc_write = mr; c.ir_write = mr;
        return c;
    endfunction
    function automatic ctl_t c_decode();
        ctl_t c = '0;
        c.alu_src_b = 2'b11;
        return c;
    endfunction
    function automatic ctl_t c_exec_r();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 3'b011;
        return c;
    endfunction
    function automatic ctl_t c_exec_i(input logic [2:0] op);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op;
        return c;
    endfunction
    function automatic ctl_t c_alu_wb(input logic rd);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = rd; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_mem_addr();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        return c;
    endfunction
    function automatic ctl_t c_mem_rd();
        ctl_t c = '0;
        c.mem_read = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_mem_wb();
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_mem_wr(input logic mr);
        ctl_t c = '0;
        c.mem_write = 1'b1; c.instr_done = mr;
        return c;
    endfunction
    function automatic ctl_t c_branch(input logic pcw);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'b01;
        c.pc_write = pcw; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_jump();
        ctl_t c = '0;
        c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_illegal();
        ctl_t c = '0;
        c.illegal_op = 1'b1;
        return c;
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [3:0] st, input ctl_t c);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.ctl  = c;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        if (c.instr_done) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    // FETCH and DECODE with mem_ready high; opcode is scrambled afterwards to prove it was latched.
    task automatic fetch_decode(input string name, input logic [3:0] op);
        bus.opcode    = op;
        bus.mem_ready = 1'b1;
        cyc({name, ".fetch"}, ST_FETCH, c_fetch(1'b1));
        cyc({name, ".decode"}, ST_DECODE, c_decode());
        bus.opcode = ~op;
    endtask

    task automatic run_imm(input string name, input logic [3:0] op, input logic [2:0] alu);
        fetch_decode(name, op);
        cyc({name, ".exec_i"}, ST_EXEC_I, c_exec_i(alu));
        cyc({name, ".alu_wb"}, ST_ALU_WB, c_alu_wb(1'b0));
    endtask

    task automatic run_branch(input string name, input logic [3:0] op, input logic z, input logic pcw);
        fetch_decode(name, op);
        bus.zero = z;
        cyc({name, ".branch"}, ST_BRANCH, c_branch(pcw));
        bus.zero = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 4'b0000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", ST_FETCH, '0);
        reset = 1'b0;

        // R-type: 4 cycles, reg_dst=1 at write-back
        fetch_decode("rtype", 4'b0000);
        cyc("rtype.exec_r", ST_EXEC_R, c_exec_r());
        cyc("rtype.alu_wb", ST_ALU_WB, c_alu_wb(1'b1));

        run_imm("andi", 4'b0010, 3'b100);
        run_imm("ori",  4'b0011, 3'b101);
        run_imm("nori", 4'b0100, 3'b111);
        run_imm("slti", 4'b0101, 3'b110);
        run_imm("addi", 4'b0001, 3'b000);

        // lw with two stall cycles in MEM_RD: 7 cycles total
        fetch_decode("lw", 4'b0110);
        cyc("lw.mem_addr", ST_MEM_ADDR, c_mem_addr());
        bus.mem_ready = 1'b0;
        cyc("lw.mem_rd0", ST_MEM_RD, c_mem_rd());
        cyc("lw.mem_rd1", ST_MEM_RD, c_mem_rd());
        bus.mem_ready = 1'b1;
        cyc("lw.mem_rd2", ST_MEM_RD, c_mem_rd());
        cyc("lw.mem_wb", ST_MEM_WB, c_mem_wb());

        // sw with one stall in FETCH and one in MEM_WR
        bus.opcode    = 4'b0111;
        bus.mem_ready = 1'b0;
        cyc("sw.fetch_wait", ST_FETCH, c_fetch(1'b0));
        fetch_decode("sw", 4'b0111);
        cyc("sw.mem_addr", ST_MEM_ADDR, c_mem_addr());
        bus.mem_ready = 1'b0;
        cyc("sw.mem_wr_wait", ST_MEM_WR, c_mem_wr(1'b0));
        bus.mem_ready = 1'b1;
        cyc("sw.mem_wr", ST_MEM_WR, c_mem_wr(1'b1));

        run_branch("beq_z1", 4'b1000, 1'b1, 1'b1);
        run_branch("beq_z0", 4'b1000, 1'b0, 1'b0);
        run_branch("bne_z1", 4'b1001, 1'b1, 1'b0);
        run_branch("bne_z0", 4'b1001, 1'b0, 1'b1);

        fetch_decode("j", 4'b1010);
        cyc("j.jump", ST_JUMP, c_jump());

        fetch_decode("ill_f", 4'b1111);
        cyc("ill_f.illegal", ST_ILLEGAL, c_illegal());
        fetch_decode("ill_b", 4'b1011);
        cyc("ill_b.illegal", ST_ILLEGAL, c_illegal());

        // Reset in MEM_WR with mem_ready high: abandoned, counter cleared, back in FETCH
        fetch_decode("sw_rst", 4'b0111);
        cyc("sw_rst.mem_addr", ST_MEM_ADDR, c_mem_addr());
        bus.mem_ready = 1'b0;
        cyc("sw_rst.mem_wr", ST_MEM_WR, c_mem_wr(1'b0));
        bus.mem_ready = 1'b1;
        reset         = 1'b1;
        exp_cnt       = '0;
        cyc("sw_rst.reset", ST_FETCH, '0);
        reset = 1'b0;

        // Counter wrap: 2**TB_CNT_W jumps bring it through all-ones back to zero
        for (int i = 0; i < (1 << TB_CNT_W); i++) begin
            fetch_decode("wrap", 4'b1010);
            cyc("wrap.jump", ST_JUMP, c_jump());
        end
        bus.opcode = 4'b0000;
        cyc("wrap.final", ST_FETCH, c_fetch(1'b1));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control FSM for the 16-bit datapath. It sits upstream of the ALU control decoder and produces the 3-bit `alu_op` that the decoder consumes, together with every datapath enable and mux select. Memory accesses are stretched by a `mem_ready` handshake. It also keeps a count of retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  4  instruction opcode (IR[15:12]); sampled only in DECODE
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory done; may be held high
- pc_write  out  1  unconditional PC load
- ir_write  out  1  instruction register load
- mem_read / mem_write  out  1 each  memory strobes
- reg_write  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 1, 10 = sign-ext imm, 11 = branch offset
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  3  000 add, 001 sub, 011 R-type (defer to funct), 100 and, 101 or, 110 slt, 111 nor
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- retired_count  out  CNT_W  retired instructions; wraps
- state  out  4  current state (debug)

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 addi, 0010 andi, 0011 ori, 0100 nori, 0101 slti
  - 0110 lw, 0111 sw
  - 1000 beq, 1001 bne
  - 1010 j
  - 1011–1111 illegal
- States and outputs:
  - FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. pc_write and ir_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
  - DECODE: latch opcode into an internal register; alu_src_a=0, alu_src_b=11, alu_op=000. Next state is chosen by opcode.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=011 → ALU_WB.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per opcode (addi 000, andi 100, ori 101, nori 111, slti 110) → ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type; instr_done → FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_read=1; wait for mem_ready → MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done → FETCH.
  - MEM_WR: mem_write=1; wait for mem_ready, then instr_done → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01; pc_write = zero XOR is_bne; instr_done → FETCH.
  - JUMP: pc_source=10, pc_write=1; instr_done → FETCH.
  - ILLEGAL: illegal_op=1, no writes, no retire → FETCH.
- Any output not listed for a state is 0.
- retired_count increments in every cycle where instr_done=1 and wraps from all-ones to 0.

## Timing
- Outputs are Moore, decoded from the state register; BRANCH pc_write is the only output that also depends on `zero`.
- The opcode latched in DECODE governs the whole instruction; later changes on `opcode` are ignored.
- Cycle counts with mem_ready held high:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
  - illegal: 3
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset:
  - While reset=1, all outputs are forced to 0.
  - On the first edge with reset=1, state becomes FETCH, retired_count becomes 0 and the latched opcode becomes 0000.
  - Reset mid-instruction abandons the instruction with no retire.
- instr_done and the counter increment happen in the same cycle; the counter shows the new value on the following edge.

## Structure
- Shared package holds:
  - opcode constants
  - alu_op codes (shared with the ALU control decoder)
  - alu_src_b and pc_source encodings
  - the state enumeration, encoded as FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, ILLEGAL=11
- There are no sub-modules; the counter is inline.

## Test plan
- Reset, then R-type (opcode 0000) with mem_ready=1 → states 0,1,2,4; alu_op=011 in EXEC_R; reg_write=1 and reg_dst=1 in ALU_WB; retired_count=1.
- andi (0010) → alu_op=100 in EXEC_I; ALU_WB with reg_dst=0. ori (0011) → alu_op=101.
- lw (0110) with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_to_reg=1 in MEM_WB.
- beq with zero=1 → pc_write=1 in BRANCH. bne with zero=1 → pc_write=0. Both retire.
- Opcode 1111 → illegal_op pulses once, no reg_write or mem_write, count unchanged. Reset asserted during MEM_WR → next state FETCH, count 0.
- Preload the count to 16'hFFFF by running 65535 instructions, then retire one more → count wraps to 0.
